// File: rtl/iq_symbol_sync.sv
// Symbol-timing recovery: picks the strongest sample phase per window and emits DBPSK products/decisions.
// Latency: strobe_out, DI, DQ and bit_out appear 1 clk after the qualifying strobe_in.
// Backpressure: none; every strobe_in with ce=1 is consumed, and back-to-back strobes are supported.
module iq_symbol_sync #(
   parameter int DATA_WIDTH   = 16,
   parameter int SPS          = 5,
   parameter int WIN_LOG2     = 5,
   parameter int AVE_SHIFT    = 4,
   parameter int LOCK_WINDOWS = 3
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         ce,
   input  logic                         strobe_in,
   input  logic signed [DATA_WIDTH-1:0] I_in,
   input  logic signed [DATA_WIDTH-1:0] Q_in,
   input  logic        [DATA_WIDTH-1:0] Amp_in,
   input  logic                         hold_sync,
   output logic                         strobe_out,
   output logic signed [2*DATA_WIDTH:0] DI,
   output logic signed [2*DATA_WIDTH:0] DQ,
   output logic                         bit_out,
   output logic        [6:0]            bits_count,
   output logic        [DATA_WIDTH-1:0] Ave_Amp_Out,
   output logic        [DATA_WIDTH-1:0] Max_Amp,
   output logic        [2:0]            sync_count,
   output logic        [2:0]            max_sync,
   output logic                         locked
);

   localparam int ACC_W = DATA_WIDTH + WIN_LOG2;
   localparam int PW    = 2*DATA_WIDTH + 1;
   localparam logic [2:0] LAST_PH = 3'(SPS-1);
   localparam logic [2:0] LOCK_N  = 3'(LOCK_WINDOWS);

   logic [ACC_W-1:0]             acc     [SPS];
   logic [ACC_W-1:0]             acc_inc [SPS];
   logic [WIN_LOG2-1:0]          sym_cnt;
   logic [2:0]                   lock_cnt;
   logic [2:0]                   lock_cnt_inc;
   logic                         valid;
   logic signed [DATA_WIDTH-1:0] i_prev;
   logic signed [DATA_WIDTH-1:0] q_prev;
   logic                         strobe_r;

   logic                         take;
   logic                         sym_end;
   logic                         win_end;
   logic                         decide;
   logic                         phase_change;
   logic [ACC_W-1:0]             best_val;
   logic [2:0]                   best_idx;
   logic [2:0]                   winner;
   logic                         cur_tied;

   logic signed [2*DATA_WIDTH-1:0] p_ii, p_qq, p_qi, p_iq;
   logic signed [PW-1:0]           di_calc, dq_calc;
   logic signed [DATA_WIDTH:0]     ave_diff, ave_step, ave_sum;

   assign take         = ce & strobe_in;
   assign sym_end      = take && (sync_count == LAST_PH);
   assign win_end      = sym_end && (&sym_cnt);
   // decision compares against the registered phase, so a same-cycle window update never affects it
   assign decide       = take && (sync_count == max_sync);
   assign phase_change = win_end && !hold_sync && (winner != max_sync);
   assign lock_cnt_inc = (lock_cnt == LOCK_N) ? lock_cnt : lock_cnt + 3'd1;

   // differential products against the previous decision-phase sample
   assign p_ii    = I_in * i_prev;
   assign p_qq    = Q_in * q_prev;
   assign p_qi    = Q_in * i_prev;
   assign p_iq    = I_in * q_prev;
   assign di_calc = PW'(p_ii) + PW'(p_qq);
   assign dq_calc = PW'(p_qi) - PW'(p_iq);

   // amplitude IIR step in one extra signed bit; arithmetic shift floors toward -inf
   assign ave_diff = $signed({1'b0, Amp_in}) - $signed({1'b0, Ave_Amp_Out});
   assign ave_step = ave_diff >>> AVE_SHIFT;
   assign ave_sum  = $signed({1'b0, Ave_Amp_Out}) + ave_step;

   // accumulators including the current sample, then argmax with preference for the current phase
   always_comb begin
      for (int p = 0; p < SPS; p++) begin
         acc_inc[p] = (sync_count == 3'(p)) ? acc[p] + ACC_W'(Amp_in) : acc[p];
      end
      best_val = acc_inc[0];
      best_idx = 3'd0;
      for (int p = 1; p < SPS; p++) begin
         if (acc_inc[p] > best_val) begin
            best_val = acc_inc[p];
            best_idx = 3'(p);
         end
      end
      cur_tied = 1'b0;
      for (int p = 0; p < SPS; p++) begin
         if ((max_sync == 3'(p)) && (acc_inc[p] == best_val)) cur_tied = 1'b1;
      end
      winner = cur_tied ? max_sync : best_idx;
   end

   // sample phase, symbol counter and per-phase accumulation
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync_count <= 3'd0;
         sym_cnt    <= '0;
         for (int p = 0; p < SPS; p++) acc[p] <= '0;
      end else if (take) begin
         sync_count <= (sync_count == LAST_PH) ? 3'd0 : sync_count + 3'd1;
         if (sym_end) sym_cnt <= sym_cnt + 1'b1;
         for (int p = 0; p < SPS; p++) acc[p] <= win_end ? '0 : acc_inc[p];
      end
   end

   // end-of-window phase selection and lock tracking
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         max_sync <= 3'd0;
         Max_Amp  <= '0;
         lock_cnt <= 3'd0;
         locked   <= 1'b0;
      end else if (win_end) begin
         Max_Amp <= best_val[ACC_W-1:WIN_LOG2];
         if (phase_change) begin
            max_sync <= winner;
            lock_cnt <= 3'd0;
            locked   <= 1'b0;
         end else begin
            lock_cnt <= lock_cnt_inc;
            locked   <= (lock_cnt_inc == LOCK_N);
         end
      end
   end

   // DBPSK decision; a phase change invalidates the stored reference sample
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         valid      <= 1'b0;
         i_prev     <= '0;
         q_prev     <= '0;
         DI         <= '0;
         DQ         <= '0;
         bit_out    <= 1'b0;
         bits_count <= 7'd0;
         strobe_r   <= 1'b0;
      end else begin
         strobe_r <= 1'b0;
         if (decide) begin
            i_prev <= I_in;
            q_prev <= Q_in;
            valid  <= 1'b1;
            if (valid) begin
               DI         <= di_calc;
               DQ         <= dq_calc;
               bit_out    <= di_calc[PW-1];
               bits_count <= bits_count + 7'd1;
               strobe_r   <= 1'b1;
            end
         end
         if (phase_change) valid <= 1'b0;
      end
   end

   // running mean amplitude, updated on every accepted sample
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) Ave_Amp_Out <= '0;
      else if (take) Ave_Amp_Out <= ave_sum[DATA_WIDTH-1:0];
   end

   assign strobe_out = strobe_r & ce;

endmodule

// File: tb/tb_iq_symbol_sync.sv
// Bench for iq_symbol_sync: window table, hand sequences for decisions/ce/reset/wrap, then random traffic.
// Every cycle is compared against a window-level reference model held in this file.
// Inputs are driven on the falling edge; outputs are sampled on the following falling edge.
module tb_iq_symbol_sync;
   localparam int DW   = 16;
   localparam int SPS  = 5;
   localparam int WL   = 2;
   localparam int AS   = 4;
   localparam int LW   = 2;
   localparam int NSYM = 1 << WL;
   localparam int WLEN = SPS * NSYM;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic ce = 1'b0;
   logic strobe_in = 1'b0;
   logic signed [DW-1:0] I_in = '0;
   logic signed [DW-1:0] Q_in = '0;
   logic [DW-1:0] Amp_in = '0;
   logic hold_sync = 1'b0;
   logic strobe_out;
   logic signed [2*DW:0] DI, DQ;
   logic bit_out;
   logic [6:0] bits_count;
   logic [DW-1:0] Ave_Amp_Out, Max_Amp;
   logic [2:0] sync_count, max_sync;
   logic locked;

   iq_symbol_sync #(.DATA_WIDTH(DW), .SPS(SPS), .WIN_LOG2(WL), .AVE_SHIFT(AS), .LOCK_WINDOWS(LW)) dut (
      .clk(clk), .rst(rst), .ce(ce), .strobe_in(strobe_in), .I_in(I_in), .Q_in(Q_in),
      .Amp_in(Amp_in), .hold_sync(hold_sync), .strobe_out(strobe_out), .DI(DI), .DQ(DQ),
      .bit_out(bit_out), .bits_count(bits_count), .Ave_Amp_Out(Ave_Amp_Out), .Max_Amp(Max_Amp),
      .sync_count(sync_count), .max_sync(max_sync), .locked(locked));

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail = 0;

   task automatic check(input string name, input longint act, input longint exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: actual %0d, required %0d", name, act, exp);
      end
   endtask

   // reference model state
   int     m_pos, m_max, m_lock, m_bits, m_ave, m_maxamp, m_bit;
   bit     m_valid, m_locked;
   longint m_ip, m_qp, m_di, m_dq;
   int     m_win[$];

   int pat[SPS] = '{10, 30, 50, 30, 10};
   int prev_bits = 0;
   bit saw_wrap = 1'b0;
   bit saw_after = 1'b0;

   function automatic void model_reset();
      m_pos = 0; m_max = 0; m_lock = 0; m_bits = 0; m_ave = 0; m_maxamp = 0; m_bit = 0;
      m_valid = 1'b0; m_locked = 1'b0;
      m_ip = 0; m_qp = 0; m_di = 0; m_dq = 0;
      m_win.delete();
   endfunction

   task automatic model_strobe(input int amp, input int iv, input int qv, input bit h, output bit es);
      int ph, d, best, win;
      int sums[SPS];
      es = 1'b0;
      ph = m_pos % SPS;
      if (ph == m_max) begin
         if (m_valid) begin
            m_di = longint'(iv) * m_ip + longint'(qv) * m_qp;
            m_dq = longint'(qv) * m_ip - longint'(iv) * m_qp;
            m_bit = (m_di < 0) ? 1 : 0;
            m_bits = (m_bits + 1) % 128;
            es = 1'b1;
         end
         m_ip = iv; m_qp = qv; m_valid = 1'b1;
      end
      d = amp - m_ave;
      if (d >= 0) m_ave = m_ave + d / (1 << AS);
      else        m_ave = m_ave - (-d + (1 << AS) - 1) / (1 << AS);
      m_win.push_back(amp);
      if (m_win.size() == WLEN) begin
         for (int p = 0; p < SPS; p++) sums[p] = 0;
         for (int k = 0; k < WLEN; k++) sums[k % SPS] += m_win[k];
         best = 0;
         for (int p = 0; p < SPS; p++) if (sums[p] > best) best = sums[p];
         win = -1;
         for (int p = SPS-1; p >= 0; p--) if (sums[p] == best) win = p;
         if (sums[m_max] == best) win = m_max;
         m_maxamp = sums[win] / NSYM;
         if (!h && win != m_max) begin
            m_max = win; m_lock = 0; m_locked = 1'b0; m_valid = 1'b0;
         end else begin
            if (m_lock < LW) m_lock++;
            m_locked = (m_lock >= LW);
         end
         m_win.delete();
      end
      m_pos++;
   endtask

   task automatic compare_all(input bit es);
      check("sync_count", sync_count, m_pos % SPS);
      check("max_sync", max_sync, m_max);
      check("locked", locked, m_locked);
      check("Max_Amp", Max_Amp, m_maxamp);
      check("Ave_Amp_Out", Ave_Amp_Out, m_ave);
      check("bits_count", bits_count, m_bits);
      check("strobe_out", strobe_out, es);
      check("DI", $signed(DI), m_di);
      check("DQ", $signed(DQ), m_dq);
      check("bit_out", bit_out, m_bit);
   endtask

   task automatic do_cycle(input bit stb, input int amp, input int iv, input int qv, input bit h, input bit c);
      bit es;
      es = 1'b0;
      strobe_in = stb; Amp_in = 16'(amp); I_in = 16'(iv); Q_in = 16'(qv); hold_sync = h; ce = c;
      @(negedge clk);
      if (stb && c) model_strobe(amp, iv, qv, h, es);
      compare_all(es);
      if (strobe_out) begin
         if (prev_bits == 127 && bits_count == 7'd0) saw_wrap = 1'b1;
         if (saw_wrap && prev_bits == 0 && bits_count == 7'd1) saw_after = 1'b1;
         prev_bits = bits_count;
      end
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_strobe_out"}, strobe_out, 0);
      check({tag, "_DI"}, $signed(DI), 0);
      check({tag, "_DQ"}, $signed(DQ), 0);
      check({tag, "_bit_out"}, bit_out, 0);
      check({tag, "_bits_count"}, bits_count, 0);
      check({tag, "_Ave_Amp_Out"}, Ave_Amp_Out, 0);
      check({tag, "_Max_Amp"}, Max_Amp, 0);
      check({tag, "_sync_count"}, sync_count, 0);
      check({tag, "_max_sync"}, max_sync, 0);
      check({tag, "_locked"}, locked, 0);
   endtask

   // asynchronous reset asserted mid-cycle, outputs checked before the next clock edge
   task automatic reset_dut(input string tag);
      #2 rst = 1'b0;
      strobe_in = 1'b0;
      #1 check_zero(tag);
      model_reset();
      @(negedge clk);
      rst = 1'b1;
      do_cycle(0, 0, 0, 0, 0, 1);
   endtask

   function automatic int rnd_s16();
      return int'($urandom_range(0, 65535)) - 32768;
   endfunction

   task automatic pat_strobe(input int ph, input int iv, input int qv);
      do_cycle(1, pat[ph], iv, qv, 0, 1);
   endtask

   typedef struct packed {
      logic [SPS-1:0][15:0] amp;
      logic                 hold;
      logic [2:0]           exp_max;
      logic [15:0]          exp_amp;
      logic                 exp_locked;
   } win_vec_t;

   function automatic win_vec_t mk(input int a0, a1, a2, a3, a4, input bit h, input int em, ea, input bit el);
      win_vec_t v;
      v.amp[0] = 16'(a0); v.amp[1] = 16'(a1); v.amp[2] = 16'(a2);
      v.amp[3] = 16'(a3); v.amp[4] = 16'(a4);
      v.hold = h; v.exp_max = 3'(em); v.exp_amp = 16'(ea); v.exp_locked = el;
      return v;
   endfunction

   win_vec_t tbl[11];

   initial begin
      // one window per row, applied from reset with back-to-back strobes; LOCK_WINDOWS=2
      tbl[0]  = mk(10, 30, 50, 30, 10, 0, 2, 50, 0);  // phase 0 -> 2
      tbl[1]  = mk(10, 30, 50, 30, 10, 0, 2, 50, 0);  // one stable window
      tbl[2]  = mk(10, 30, 50, 30, 10, 0, 2, 50, 1);  // two stable windows: locked
      tbl[3]  = mk(10, 20, 30, 40, 50, 1, 2, 50, 1);  // peak at 4 but held
      tbl[4]  = mk(10, 20, 30, 40, 50, 0, 4, 50, 0);  // released: move to 4, lock drops
      tbl[5]  = mk(20, 20, 20, 20, 20, 0, 4, 20, 0);  // full tie keeps current phase
      tbl[6]  = mk(60, 10, 10, 10, 10, 0, 0, 60, 0);
      tbl[7]  = mk(20, 20, 20, 20, 20, 0, 0, 20, 0);
      tbl[8]  = mk( 5, 40, 40,  5,  5, 0, 1, 40, 0);  // tie not on current phase -> lowest index
      tbl[9]  = mk( 5, 40, 40,  5,  5, 0, 1, 40, 0);
      tbl[10] = mk( 5, 40, 40,  5,  5, 0, 1, 40, 1);

      model_reset();
      #1 rst = 1'b0;
      #2 check_zero("reset");
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      do_cycle(0, 0, 0, 0, 0, 1);

      for (int r = 0; r < 11; r++) begin
         for (int s = 0; s < NSYM; s++)
            for (int ph = 0; ph < SPS; ph++)
               do_cycle(1, int'(tbl[r].amp[ph]), rnd_s16(), rnd_s16(), tbl[r].hold, 1);
         check("tbl_max_sync", max_sync, tbl[r].exp_max);
         check("tbl_Max_Amp", Max_Amp, tbl[r].exp_amp);
         check("tbl_locked", locked, tbl[r].exp_locked);
      end

      // all-equal window from reset, then ce stall in the middle of the next window
      reset_dut("reset2");
      for (int k = 0; k < WLEN; k++) do_cycle(1, 20, 0, 0, 0, 1);
      check("tie_from_reset_max_sync", max_sync, 0);
      check("tie_from_reset_Max_Amp", Max_Amp, 20);
      for (int k = 0; k < 12; k++) pat_strobe(k % SPS, rnd_s16(), rnd_s16());
      for (int k = 0; k < 30; k++) do_cycle(1, 65535, rnd_s16(), rnd_s16(), 0, 0);
      check("ce_stall_sync_count", sync_count, 2);
      check("ce_stall_strobe_out", strobe_out, 0);
      for (int k = 12; k < WLEN; k++) pat_strobe(k % SPS, rnd_s16(), rnd_s16());
      check("ce_resume_max_sync", max_sync, 2);
      check("ce_resume_Max_Amp", Max_Amp, 50);

      // mid-window reset, reacquisition with gaps between strobes, then DBPSK decisions
      for (int k = 0; k < 7; k++) pat_strobe(k % SPS, rnd_s16(), rnd_s16());
      reset_dut("reset3");
      check("restart_sync_count", sync_count, 0);
      for (int k = 0; k < WLEN; k++) begin
         pat_strobe(k % SPS, 0, 0);
         do_cycle(0, 0, 0, 0, 0, 1);
      end
      check("acq_max_sync", max_sync, 2);
      check("acq_Max_Amp", Max_Amp, 50);
      // three phase-0 decisions were issued during acquisition, so bits_count starts at 3 here
      pat_strobe(0, 0, 0); pat_strobe(1, 0, 0); pat_strobe(2, 30, 40);
      check("dec1_suppressed", strobe_out, 0);
      check("dec1_bits_hold", bits_count, 3);
      do_cycle(0, 0, 0, 0, 0, 1);
      pat_strobe(3, 0, 0); pat_strobe(4, 0, 0);
      pat_strobe(0, 0, 0); pat_strobe(1, 0, 0); pat_strobe(2, -30, -40);
      check("dec2_strobe_out", strobe_out, 1);
      check("dec2_DI", $signed(DI), -2500);
      check("dec2_DQ", $signed(DQ), 0);
      check("dec2_bit_out", bit_out, 1);
      check("dec2_bits_count", bits_count, 4);
      do_cycle(0, 0, 0, 0, 0, 1);
      check("dec2_pulse_width", strobe_out, 0);
      check("dec2_DI_stable", $signed(DI), -2500);
      pat_strobe(3, 0, 0); pat_strobe(4, 0, 0);
      pat_strobe(0, 0, 0); pat_strobe(1, 0, 0); pat_strobe(2, -30, -40);
      check("dec3_strobe_out", strobe_out, 1);
      check("dec3_DI", $signed(DI), 2500);
      check("dec3_bit_out", bit_out, 0);
      check("dec3_bits_count", bits_count, 5);
      pat_strobe(3, 0, 0); pat_strobe(4, 0, 0);

      // 140 more valid decisions: 5 + 140 = 145 -> wraps through 127, 0, 1 and ends at 17
      prev_bits = bits_count;
      for (int s = 0; s < 140; s++)
         for (int ph = 0; ph < SPS; ph++) pat_strobe(ph, rnd_s16(), rnd_s16());
      check("wrap_bits_count", bits_count, 17);
      check("wrap_127_to_0_to_1", saw_after, 1);

      // random traffic with random ce/hold and one reset in the middle
      for (int k = 0; k < 1500; k++) begin
         if (k == 700) reset_dut("reset_rand");
         do_cycle($urandom_range(0, 3) != 0, int'($urandom_range(0, 65535)), rnd_s16(), rnd_s16(),
                  $urandom_range(0, 7) == 0, $urandom_range(0, 9) != 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
